// File: rtl/cpu_id_operand_stage.sv
// Decode / operand stage sitting between IF and EX.
// Decodes MIPS I-type ALU ops and SPECIAL R-type ALU/shift ops, resolves both
// source operands through a prioritised forwarding network (index 0 youngest),
// stalls on load-use hazards, and presents a registered ID/EX bundle.
//
// Handshake: a transfer on either side happens on a rising clk edge where
// valid && ready are both high. The input side accepts when in_valid && in_ready.
// The output bundle is consumed when out_valid && out_ready. While out_valid is
// high and out_ready is low, the bundle holds stable. in_ready is combinational
// and never looks at flush; flush only blocks the capture itself.

package cpu_id_operand_pkg;

  typedef enum logic [4:0] {
    OP_INVALID = 5'd0,
    OP_ADD     = 5'd1,
    OP_ADDU    = 5'd2,
    OP_SUB     = 5'd3,
    OP_SUBU    = 5'd4,
    OP_AND     = 5'd5,
    OP_OR      = 5'd6,
    OP_XOR     = 5'd7,
    OP_NOR     = 5'd8,
    OP_SLT     = 5'd9,
    OP_SLTU    = 5'd10,
    OP_SLL     = 5'd11,
    OP_SRL     = 5'd12,
    OP_SRA     = 5'd13,
    OP_ADDI    = 5'd14,
    OP_ADDIU   = 5'd15,
    OP_SLTI    = 5'd16,
    OP_SLTIU   = 5'd17,
    OP_ANDI    = 5'd18,
    OP_ORI     = 5'd19,
    OP_XORI    = 5'd20,
    OP_LUI     = 5'd21
  } Oper_t;

endpackage

module cpu_id_operand_stage
  import cpu_id_operand_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_FWD     = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               inst,
  output logic [4:0]                reg_raddr1,
  output logic [4:0]                reg_raddr2,
  input  logic [DATA_W-1:0]         reg1_i,
  input  logic [DATA_W-1:0]         reg2_i,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [5*NUM_FWD-1:0]      fwd_waddr,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_rdy,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output Oper_t                     op,
  output logic [DATA_W-1:0]         reg1_o,
  output logic [DATA_W-1:0]         reg2_o,
  output logic                      reg_we,
  output logic [4:0]                reg_waddr,
  output logic                      illegal,
  output logic [STALL_CNT_W-1:0]    stall_cnt
);

  // Instruction shape drives which operands are used and how reg2 is formed.
  typedef enum logic [2:0] {
    K_BAD   = 3'd0,
    K_IMM_S = 3'd1,
    K_IMM_Z = 3'd2,
    K_RTYPE = 3'd3,
    K_SHIFT = 3'd4
  } kind_t;

  // Instruction fields
  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_sa;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;

  assign w_opcode = inst[31:26];
  assign w_rs     = inst[25:21];
  assign w_rt     = inst[20:16];
  assign w_rd     = inst[15:11];
  assign w_sa     = inst[10:6];
  assign w_funct  = inst[5:0];
  assign w_imm    = inst[15:0];

  assign reg_raddr1 = w_rs;
  assign reg_raddr2 = w_rt;

  // Decode results
  Oper_t       w_op;
  kind_t       w_kind;
  logic        w_illegal;
  logic        w_we;
  logic [4:0]  w_waddr;
  logic        w_use_rs;
  logic        w_use_rt;

  // Forwarding results
  logic              w_hit1;
  logic              w_rdy1;
  logic [DATA_W-1:0] w_fdata1;
  logic              w_hit2;
  logic              w_rdy2;
  logic [DATA_W-1:0] w_fdata2;
  logic [DATA_W-1:0] w_opnd1;
  logic [DATA_W-1:0] w_opnd2;
  logic              w_haz1;
  logic              w_haz2;
  logic              w_hazard;

  // Final operand values to capture
  logic [DATA_W-1:0] w_reg1;
  logic [DATA_W-1:0] w_reg2;

  // Registered ID/EX bundle
  logic                   r_out_valid;
  Oper_t                  r_op;
  logic [DATA_W-1:0]      r_reg1;
  logic [DATA_W-1:0]      r_reg2;
  logic                   r_we;
  logic [4:0]             r_waddr;
  logic                   r_illegal;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic w_accept;

  // Opcode / funct decode into an operation and an instruction shape.
  always_comb begin
    w_op   = OP_INVALID;
    w_kind = K_BAD;
    if (w_opcode == 6'h00) begin
      case (w_funct)
        6'h00: begin w_op = OP_SLL;  w_kind = K_SHIFT; end
        6'h02: begin w_op = OP_SRL;  w_kind = K_SHIFT; end
        6'h03: begin w_op = OP_SRA;  w_kind = K_SHIFT; end
        6'h20: begin w_op = OP_ADD;  w_kind = K_RTYPE; end
        6'h21: begin w_op = OP_ADDU; w_kind = K_RTYPE; end
        6'h22: begin w_op = OP_SUB;  w_kind = K_RTYPE; end
        6'h23: begin w_op = OP_SUBU; w_kind = K_RTYPE; end
        6'h24: begin w_op = OP_AND;  w_kind = K_RTYPE; end
        6'h25: begin w_op = OP_OR;   w_kind = K_RTYPE; end
        6'h26: begin w_op = OP_XOR;  w_kind = K_RTYPE; end
        6'h27: begin w_op = OP_NOR;  w_kind = K_RTYPE; end
        6'h2A: begin w_op = OP_SLT;  w_kind = K_RTYPE; end
        6'h2B: begin w_op = OP_SLTU; w_kind = K_RTYPE; end
        default: begin w_op = OP_INVALID; w_kind = K_BAD; end
      endcase
    end else begin
      case (w_opcode)
        6'h08: begin w_op = OP_ADDI;  w_kind = K_IMM_S; end
        6'h09: begin w_op = OP_ADDIU; w_kind = K_IMM_S; end
        6'h0A: begin w_op = OP_SLTI;  w_kind = K_IMM_S; end
        6'h0B: begin w_op = OP_SLTIU; w_kind = K_IMM_S; end
        6'h0C: begin w_op = OP_ANDI;  w_kind = K_IMM_Z; end
        6'h0D: begin w_op = OP_ORI;   w_kind = K_IMM_Z; end
        6'h0E: begin w_op = OP_XORI;  w_kind = K_IMM_Z; end
        6'h0F: begin w_op = OP_LUI;   w_kind = K_IMM_Z; end
        default: begin w_op = OP_INVALID; w_kind = K_BAD; end
      endcase
    end
  end

  // Destination and source usage derived from the instruction shape.
  always_comb begin
    w_illegal = (w_kind == K_BAD);
    w_we      = !w_illegal;
    w_use_rs  = (w_kind == K_IMM_S) || (w_kind == K_IMM_Z) || (w_kind == K_RTYPE);
    w_use_rt  = (w_kind == K_RTYPE) || (w_kind == K_SHIFT);
    case (w_kind)
      K_IMM_S, K_IMM_Z: w_waddr = w_rt;
      K_RTYPE, K_SHIFT: w_waddr = w_rd;
      default:          w_waddr = 5'd0;
    endcase
  end

  // Forward lookup: scan oldest to youngest so the youngest match wins,
  // including when that youngest match is not ready yet.
  always_comb begin
    w_hit1   = 1'b0;
    w_rdy1   = 1'b0;
    w_fdata1 = '0;
    w_hit2   = 1'b0;
    w_rdy2   = 1'b0;
    w_fdata2 = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_we[k] && (fwd_waddr[5*k +: 5] == w_rs)) begin
        w_hit1   = 1'b1;
        w_rdy1   = fwd_rdy[k];
        w_fdata1 = fwd_wdata[DATA_W*k +: DATA_W];
      end
      if (fwd_we[k] && (fwd_waddr[5*k +: 5] == w_rt)) begin
        w_hit2   = 1'b1;
        w_rdy2   = fwd_rdy[k];
        w_fdata2 = fwd_wdata[DATA_W*k +: DATA_W];
      end
    end
  end

  // Operand resolution: r0 is hard zero and never hazards.
  always_comb begin
    w_opnd1 = '0;
    w_opnd2 = '0;
    w_haz1  = 1'b0;
    w_haz2  = 1'b0;
    if (w_rs != 5'd0) begin
      w_opnd1 = w_hit1 ? w_fdata1 : reg1_i;
      w_haz1  = w_hit1 && !w_rdy1;
    end
    if (w_rt != 5'd0) begin
      w_opnd2 = w_hit2 ? w_fdata2 : reg2_i;
      w_haz2  = w_hit2 && !w_rdy2;
    end
  end

  // Select what lands in reg1/reg2 for each instruction shape.
  always_comb begin
    w_reg1 = '0;
    w_reg2 = '0;
    case (w_kind)
      K_IMM_S: begin
        w_reg1 = w_opnd1;
        w_reg2 = {{(DATA_W-16){w_imm[15]}}, w_imm};
      end
      K_IMM_Z: begin
        w_reg1 = w_opnd1;
        w_reg2 = {{(DATA_W-16){1'b0}}, w_imm};
      end
      K_RTYPE: begin
        w_reg1 = w_opnd1;
        w_reg2 = w_opnd2;
      end
      K_SHIFT: begin
        w_reg1 = {{(DATA_W-5){1'b0}}, w_sa};
        w_reg2 = w_opnd2;
      end
      default: begin
        w_reg1 = '0;
        w_reg2 = '0;
      end
    endcase
  end

  // Hazard only on operands the instruction really reads; illegal uses none.
  assign w_hazard = in_valid && ((w_use_rs && w_haz1) || (w_use_rt && w_haz2));
  assign in_ready = !w_hazard && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready && !flush;

  // ID/EX bundle register: flush beats capture, capture beats drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_op        <= OP_INVALID;
      r_reg1      <= '0;
      r_reg2      <= '0;
      r_we        <= 1'b0;
      r_waddr     <= 5'd0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_op        <= w_op;
      r_reg1      <= w_reg1;
      r_reg2      <= w_reg2;
      r_we        <= w_we;
      r_waddr     <= w_waddr;
      r_illegal   <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Saturating count of hazard-stall cycles; flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign op        = r_op;
  assign reg1_o    = r_reg1;
  assign reg2_o    = r_reg2;
  assign reg_we    = r_we;
  assign reg_waddr = r_waddr;
  assign illegal   = r_illegal;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_cpu_id_operand_stage.sv
// Bench for cpu_id_operand_stage: directed scenarios plus a randomized run
// against an instruction-level reference model with an expected-bundle queue.
module tb_cpu_id_operand_stage;
  import cpu_id_operand_pkg::*;

  localparam int DW = 32;
  localparam int NF = 2;
  localparam int SW = 4;
  localparam int BW = 5 + DW + DW + 1 + 5 + 1;
  localparam logic [SW-1:0] SAT = '1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       inst;
  logic [4:0]        reg_raddr1;
  logic [4:0]        reg_raddr2;
  logic [DW-1:0]     reg1_i;
  logic [DW-1:0]     reg2_i;
  logic [NF-1:0]     fwd_we;
  logic [5*NF-1:0]   fwd_waddr;
  logic [DW*NF-1:0]  fwd_wdata;
  logic [NF-1:0]     fwd_rdy;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  Oper_t             op;
  logic [DW-1:0]     reg1_o;
  logic [DW-1:0]     reg2_o;
  logic              reg_we;
  logic [4:0]        reg_waddr;
  logic              illegal;
  logic [SW-1:0]     stall_cnt;

  cpu_id_operand_stage #(.DATA_W(DW), .NUM_FWD(NF), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .reg_raddr1(reg_raddr1), .reg_raddr2(reg_raddr2),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata), .fwd_rdy(fwd_rdy), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .op(op), .reg1_o(reg1_o),
    .reg2_o(reg2_o), .reg_we(reg_we), .reg_waddr(reg_waddr),
    .illegal(illegal), .stall_cnt(stall_cnt)
  );

  logic [BW-1:0] dut_b;
  assign dut_b = {op, reg1_o, reg2_o, reg_we, reg_waddr, illegal};

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  logic model_ov = 1'b0;
  logic [BW-1:0] exp_q[$];

  // ---------------- encoding helpers ----------------
  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sa);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  // ---------------- reference model ----------------
  // Returns {hazard, value} for one source register.
  function automatic logic [DW:0] resolve(input logic [4:0] a, input logic [DW-1:0] rf);
    if (a == 5'd0) return '0;
    for (int k = 0; k < NF; k++) begin
      if (fwd_we[k] && fwd_waddr[5*k +: 5] == a) begin
        if (fwd_rdy[k]) return {1'b0, fwd_wdata[DW*k +: DW]};
        return {1'b1, {DW{1'b0}}};
      end
    end
    return {1'b0, rf};
  endfunction

  function automatic void model(output logic [BW-1:0] b, output logic hz);
    logic [5:0] opc;
    logic [5:0] fn;
    logic [DW:0] a1;
    logic [DW:0] a2;
    Oper_t o;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic we;
    logic [4:0] wa;
    opc = inst[31:26];
    fn  = inst[5:0];
    a1  = resolve(inst[25:21], reg1_i);
    a2  = resolve(inst[20:16], reg2_i);
    o = OP_INVALID; r1 = '0; r2 = '0; we = 1'b0; wa = 5'd0; hz = 1'b0;
    if (opc == 6'h00) begin
      case (fn)
        6'h00: o = OP_SLL;   6'h02: o = OP_SRL;   6'h03: o = OP_SRA;
        6'h20: o = OP_ADD;   6'h21: o = OP_ADDU;  6'h22: o = OP_SUB;
        6'h23: o = OP_SUBU;  6'h24: o = OP_AND;   6'h25: o = OP_OR;
        6'h26: o = OP_XOR;   6'h27: o = OP_NOR;   6'h2A: o = OP_SLT;
        6'h2B: o = OP_SLTU;  default: o = OP_INVALID;
      endcase
      if (o == OP_SLL || o == OP_SRL || o == OP_SRA) begin
        r1 = {27'd0, inst[10:6]};
        r2 = a2[DW-1:0];
        hz = a2[DW];
      end else if (o != OP_INVALID) begin
        r1 = a1[DW-1:0];
        r2 = a2[DW-1:0];
        hz = a1[DW] | a2[DW];
      end
      if (o != OP_INVALID) begin we = 1'b1; wa = inst[15:11]; end
    end else begin
      case (opc)
        6'h08: o = OP_ADDI;  6'h09: o = OP_ADDIU; 6'h0A: o = OP_SLTI;
        6'h0B: o = OP_SLTIU; 6'h0C: o = OP_ANDI;  6'h0D: o = OP_ORI;
        6'h0E: o = OP_XORI;  6'h0F: o = OP_LUI;   default: o = OP_INVALID;
      endcase
      if (o != OP_INVALID) begin
        r1 = a1[DW-1:0];
        r2 = (opc < 6'h0C) ? {{16{inst[15]}}, inst[15:0]} : {16'h0, inst[15:0]};
        hz = a1[DW];
        we = 1'b1;
        wa = inst[20:16];
      end
    end
    b = {o, r1, r2, we, wa, (o == OP_INVALID)};
  endfunction

  // Illegal bundles only promise op/we/illegal.
  function automatic logic [BW-1:0] cmp_mask(input logic ill);
    return ill ? {5'h1F, {64{1'b0}}, 1'b1, 5'h00, 1'b1} : {BW{1'b1}};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    inst      = 32'h0;
    reg1_i    = '0;
    reg2_i    = '0;
    fwd_we    = '0;
    fwd_waddr = '0;
    fwd_wdata = '0;
    fwd_rdy   = '1;
    flush     = 1'b0;
    out_ready = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({out_valid, dut_b, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state got ov=%b b=%h sc=%0d exp all zero", out_valid, dut_b, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ori();
    inst = enc_i(6'h0D, 5'd1, 5'd2, 16'hF00F);
    reg1_i = 32'h1234_0000;
    in_valid = 1'b1;
    #1;
    checks++;
    if ({in_ready, reg_raddr1, reg_raddr2} !== {1'b1, 5'd1, 5'd2}) begin
      errors++;
      $display("FAIL ori_ready_raddr got %b %0d %0d exp 1 1 2", in_ready, reg_raddr1, reg_raddr2);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, op, reg1_o, reg2_o, reg_we, reg_waddr} !==
        {1'b1, OP_ORI, 32'h1234_0000, 32'h0000_F00F, 1'b1, 5'd2}) begin
      errors++;
      $display("FAIL ori_bundle got ov=%b op=%0d r1=%h r2=%h we=%b wa=%0d", out_valid, op, reg1_o, reg2_o, reg_we, reg_waddr);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ori_drain got %b exp 0", out_valid);
    end
  endtask

  task automatic test_fwd_priority();
    inst = enc_i(6'h08, 5'd1, 5'd3, 16'hFFFF);
    reg1_i = 32'hAAAA_AAAA;
    fwd_we = 2'b11;
    fwd_waddr = {5'd1, 5'd1};
    fwd_wdata = {32'd9, 32'd5};
    fwd_rdy = 2'b11;
    in_valid = 1'b1;
    step();
    checks++;
    if ({out_valid, op, reg1_o, reg2_o, reg_waddr} !== {1'b1, OP_ADDI, 32'd5, 32'hFFFF_FFFF, 5'd3}) begin
      errors++;
      $display("FAIL fwd_youngest got ov=%b op=%0d r1=%h r2=%h wa=%0d", out_valid, op, reg1_o, reg2_o, reg_waddr);
    end
    // Younger match not ready: older ready match must not be used.
    fwd_rdy = 2'b10;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fwd_young_not_ready got in_ready=%b exp 0", in_ready);
    end
    step();
    exp_stall++;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, stall_cnt} !== {1'b0, SW'(exp_stall)}) begin
      errors++;
      $display("FAIL fwd_stall got ov=%b sc=%0d exp 0 %0d", out_valid, stall_cnt, exp_stall);
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    inst = enc_r(6'h21, 5'd1, 5'd2, 5'd4, 5'd0);
    reg1_i = 32'h11;
    reg2_i = 32'h22;
    fwd_we = 2'b01;
    fwd_waddr = {5'd0, 5'd2};
    fwd_wdata = {32'd0, 32'h0};
    fwd_rdy = 2'b10;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL load_use_stall%0d got in_ready=%b exp 0", i, in_ready);
      end
      step();
    end
    exp_stall += 3;
    checks++;
    if (stall_cnt !== SW'(exp_stall)) begin
      errors++;
      $display("FAIL load_use_count got %0d exp %0d", stall_cnt, exp_stall);
    end
    fwd_rdy = 2'b11;
    fwd_wdata = {32'd0, 32'h77};
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_use_release got in_ready=%b exp 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, op, reg1_o, reg2_o, reg_waddr} !== {1'b1, OP_ADDU, 32'h11, 32'h77, 5'd4}) begin
      errors++;
      $display("FAIL load_use_bundle got ov=%b op=%0d r1=%h r2=%h wa=%0d", out_valid, op, reg1_o, reg2_o, reg_waddr);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    inst = enc_i(6'h0D, 5'd0, 5'd5, 16'h0001);
    in_valid = 1'b1;
    step();
    inst = enc_i(6'h0D, 5'd0, 5'd6, 16'h0002);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready got %b exp 0", in_ready);
    end
    step();
    step();
    checks++;
    if ({out_valid, reg2_o, reg_waddr} !== {1'b1, 32'd1, 5'd5}) begin
      errors++;
      $display("FAIL bp_hold got ov=%b r2=%h wa=%0d exp 1 1 5", out_valid, reg2_o, reg_waddr);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got %b exp 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, reg2_o, reg_waddr} !== {1'b1, 32'd2, 5'd6}) begin
      errors++;
      $display("FAIL bp_next got ov=%b r2=%h wa=%0d exp 1 2 6", out_valid, reg2_o, reg_waddr);
    end
    step();
  endtask

  task automatic test_flush();
    inst = enc_i(6'h0D, 5'd0, 5'd7, 16'h0003);
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept got ov=%b exp 0", out_valid);
    end
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    checks++;
    if ({out_valid, stall_cnt} !== {1'b0, SW'(exp_stall)}) begin
      errors++;
      $display("FAIL flush_held got ov=%b sc=%0d exp 0 %0d", out_valid, stall_cnt, exp_stall);
    end
  endtask

  task automatic test_r0();
    inst = enc_r(6'h21, 5'd0, 5'd3, 5'd8, 5'd0);
    reg1_i = 32'h55;
    reg2_i = 32'h66;
    fwd_we = 2'b11;
    fwd_waddr = {5'd0, 5'd0};
    fwd_wdata = {32'hDEAD, 32'hDEAD};
    fwd_rdy = 2'b10;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL r0_no_hazard got in_ready=%b exp 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, reg1_o, reg2_o} !== {1'b1, 32'h0, 32'h66}) begin
      errors++;
      $display("FAIL r0_value got ov=%b r1=%h r2=%h exp 1 0 66", out_valid, reg1_o, reg2_o);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2];
    bad[0] = {6'h3F, 5'd1, 5'd1, 16'h1234};
    bad[1] = enc_r(6'h08, 5'd1, 5'd1, 5'd9, 5'd0);
    fwd_we = 2'b01;
    fwd_waddr = {5'd0, 5'd1};
    fwd_rdy = 2'b10;
    for (int i = 0; i < 2; i++) begin
      inst = bad[i];
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL illegal_no_stall%0d got in_ready=%b exp 1", i, in_ready);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, op, reg_we, illegal, stall_cnt} !== {1'b1, OP_INVALID, 1'b0, 1'b1, SW'(exp_stall)}) begin
        errors++;
        $display("FAIL illegal_bundle%0d got ov=%b op=%0d we=%b ill=%b sc=%0d", i, out_valid, op, reg_we, illegal, stall_cnt);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst = enc_i(6'h0D, 5'd0, 5'(9 + i), 16'(16'h100 + i));
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready%0d got %b exp 1", i, in_ready);
      end
      step();
      checks++;
      if ({out_valid, reg2_o, reg_waddr} !== {1'b1, 32'(32'h100 + i), 5'(9 + i)}) begin
        errors++;
        $display("FAIL b2b_bundle%0d got ov=%b r2=%h wa=%0d", i, out_valid, reg2_o, reg_waddr);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_saturate();
    inst = enc_i(6'h09, 5'd4, 5'd4, 16'h0);
    fwd_we = 2'b01;
    fwd_waddr = {5'd0, 5'd4};
    fwd_rdy = 2'b10;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) step();
    exp_stall = (exp_stall + 20 > int'(SAT)) ? int'(SAT) : exp_stall + 20;
    checks++;
    if (stall_cnt !== SW'(exp_stall)) begin
      errors++;
      $display("FAIL stall_saturate got %0d exp %0d", stall_cnt, exp_stall);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_random();
    logic [5:0] fn_tab [13];
    logic [BW-1:0] b;
    logic hz;
    logic exp_ready;
    fn_tab = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
               6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    model_ov = out_valid === 1'b1;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 3)
        inst = enc_i(6'(8 + $urandom_range(0, 7)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 16'($urandom));
      else if (sel <= 7)
        inst = enc_r(fn_tab[$urandom_range(0, 12)], 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)));
      else if (sel == 8)
        inst = {6'h3F, 26'($urandom)};
      else
        inst = enc_r(6'h08, 5'($urandom_range(0, 3)), 5'd0, 5'd1, 5'd0);
      reg1_i    = $urandom;
      reg2_i    = $urandom;
      fwd_we    = 2'($urandom);
      fwd_waddr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      fwd_wdata = {32'($urandom), 32'($urandom)};
      fwd_rdy   = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      in_valid  = $urandom_range(0, 4) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 15) == 0;
      #1;
      model(b, hz);
      hz = hz & in_valid;
      exp_ready = !hz && (!model_ov || out_ready);
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("FAIL rand_in_ready c=%0d inst=%h got %b exp %b", c, inst, in_ready, exp_ready);
      end
      if (hz && exp_stall < int'(SAT)) exp_stall++;
      if (flush) begin
        model_ov = 1'b0;
        exp_q.delete();
      end else if (in_valid && exp_ready) begin
        model_ov = 1'b1;
        exp_q.delete();
        exp_q.push_back(b);
      end else if (out_ready) begin
        model_ov = 1'b0;
        exp_q.delete();
      end
      step();
      checks++;
      if ({out_valid, stall_cnt} !== {model_ov, SW'(exp_stall)}) begin
        errors++;
        $display("FAIL rand_valid c=%0d got ov=%b sc=%0d exp %b %0d", c, out_valid, stall_cnt, model_ov, exp_stall);
      end
      if (model_ov && exp_q.size() > 0) begin
        logic [BW-1:0] m;
        m = cmp_mask(exp_q[0][0]);
        checks++;
        if ((dut_b & m) !== (exp_q[0] & m)) begin
          errors++;
          $display("FAIL rand_bundle c=%0d got %h exp %h", c, dut_b & m, exp_q[0] & m);
        end
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    inst = enc_i(6'h0D, 5'd0, 5'd3, 16'hBEEF);
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, dut_b, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid got ov=%b b=%h sc=%0d exp all zero", out_valid, dut_b, stall_cnt);
    end
    exp_stall = 0;
    model_ov = 1'b0;
    exp_q.delete();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    inst = enc_i(6'h0E, 5'd0, 5'd1, 16'h00FF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, op, reg2_o, stall_cnt} !== {1'b1, OP_XORI, 32'h00FF, SW'(0)}) begin
      errors++;
      $display("FAIL reset_resume got ov=%b op=%0d r2=%h sc=%0d", out_valid, op, reg2_o, stall_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ori();
    test_fwd_priority();
    test_load_use();
    test_backpressure();
    test_flush();
    test_r0();
    test_illegal();
    test_back_to_back();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
